// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   // Arbiter FSM: arbitrate, wait out the memory latency, return the response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Owner of the access currently in flight.
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Access size/sign in funct3 encoding (loads and stores share codes).
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Latency counter width; covers MEM_LAT up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port and the
// data port. One access in flight at a time, round-robin on conflicts.
//
// Handshake: a requester raises req with its address/data and holds them
// until it sees gnt in the same cycle; gnt and mem_req are combinational in
// IDLE. The response comes back as a one-cycle rvalid pulse MEM_LAT cycles
// after the grant. A req dropped before its grant is simply withdrawn.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_type,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [2:0]        mem_type,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_d_q, last_d_d;
   logic             we_q, we_d;

   logic pick_if;
   logic pick_d;
   logic resp_act;

   // Round-robin pick: only in IDLE and never while reset is held.
   always_comb begin
      pick_if = 1'b0;
      pick_d  = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (if_req && d_req) begin
            pick_d  = ~last_d_q;
            pick_if = last_d_q;
         end else begin
            pick_if = if_req;
            pick_d  = d_req;
         end
      end
   end

   // Next-state logic for the FSM, latency counter and owner bookkeeping.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      last_d_d = last_d_q;
      we_d     = we_q;
      case (state_q)
         IDLE: begin
            if (pick_if || pick_d) begin
               owner_d  = pick_d ? OWN_D : OWN_IF;
               last_d_d = pick_d;
               we_d     = pick_d & d_we;
               cnt_d    = LAT_M1;
               state_d  = (MEM_LAT == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            // <= 1 rather than == 1 so a corrupted count cannot strand the FSM.
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= OWN_IF;
         last_d_q <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         last_d_q <= last_d_d;
         we_q     <= we_d;
      end
   end

   // Memory strobe and payload follow the granted port; all zero otherwise.
   always_comb begin
      mem_req   = pick_if | pick_d;
      mem_we    = 1'b0;
      mem_type  = 3'b000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (pick_d) begin
         mem_we    = d_we;
         mem_type  = d_type;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (pick_if) begin
         mem_type  = LW;
         mem_addr  = if_addr;
      end
   end

   // Response routing: rvalid to the owner only, store responses carry 0.
   always_comb begin
      resp_act  = !rst && (state_q == RESP);
      if_gnt    = pick_if;
      d_gnt     = pick_d;
      if_rvalid = resp_act && (owner_q == OWN_IF);
      d_rvalid  = resp_act && (owner_q == OWN_D);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT=2 and 1), a
// behavioural memory per instance, and an event scoreboard.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int EW = 81;
   localparam logic [4:0] F_IG = 5'b11000;  // mem_req + if_gnt
   localparam logic [4:0] F_DG = 5'b10100;  // mem_req + d_gnt
   localparam logic [4:0] F_IR = 5'b00010;  // if_rvalid
   localparam logic [4:0] F_DR = 5'b00001;  // d_rvalid

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc  = 0;
   int base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT 0: MEM_LAT = 2 ----------------
   logic        if_req0 = 0, d_req0 = 0, d_we0 = 0;
   logic [31:0] if_addr0 = 0, d_addr0 = 0, d_wdata0 = 0;
   logic [2:0]  d_type0 = 0;
   logic        if_gnt0, if_rv0, d_gnt0, d_rv0, mem_req0, mem_we0;
   logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic [2:0]  mem_type0;
   logic [31:0] pipe0_a = 0, pipe0_b = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req0), .if_addr(if_addr0), .if_gnt(if_gnt0),
      .if_rvalid(if_rv0), .if_rdata(if_rdata0),
      .d_req(d_req0), .d_we(d_we0), .d_type(d_type0), .d_addr(d_addr0),
      .d_wdata(d_wdata0), .d_gnt(d_gnt0), .d_rvalid(d_rv0), .d_rdata(d_rdata0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_type(mem_type0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
   );

   // Memory returns addr ^ 0xA5A50000 exactly two cycles after the strobe.
   always @(posedge clk) begin
      pipe0_a <= mem_req0 ? (mem_addr0 ^ 32'hA5A5_0000) : 32'h0;
      pipe0_b <= pipe0_a;
   end
   assign mem_rdata0 = pipe0_b;

   // ---------------- DUT 1: MEM_LAT = 1 ----------------
   logic        if_req1 = 0;
   logic [31:0] if_addr1 = 0;
   logic        if_gnt1, if_rv1, d_gnt1, d_rv1, mem_req1, mem_we1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [2:0]  mem_type1;
   logic [31:0] pipe1_a = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
      .if_rvalid(if_rv1), .if_rdata(if_rdata1),
      .d_req(1'b0), .d_we(1'b0), .d_type(3'b000), .d_addr(32'h0),
      .d_wdata(32'h0), .d_gnt(d_gnt1), .d_rvalid(d_rv1), .d_rdata(d_rdata1),
      .mem_req(mem_req1), .mem_we(mem_we1), .mem_type(mem_type1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
   );

   always @(posedge clk) begin
      pipe1_a <= mem_req1 ? (mem_addr1 ^ 32'hA5A5_0000) : 32'h0;
   end
   assign mem_rdata1 = pipe1_a;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   logic sel = 1'b0;

   function automatic logic [EW-1:0] mk_ev(input int c, input logic [4:0] fl,
                                           input logic we, input logic [2:0] ty,
                                           input logic [31:0] a, input logic [31:0] d);
      return {8'(c), fl, we, ty, a, d};
   endfunction

   task automatic push(input int c, input logic [4:0] fl, input logic we,
                       input logic [2:0] ty, input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back(mk_ev(c, fl, we, ty, a, d));
   endtask

   // Monitor: any grant, strobe or response becomes an event to match.
   always @(negedge clk) begin : monitor
      logic [4:0]    fl;
      logic          we;
      logic [2:0]    ty;
      logic [31:0]   a, d;
      logic [EW-1:0] ev, exp_ev;
      if (!sel) begin
         fl = {mem_req0, if_gnt0, d_gnt0, if_rv0, d_rv0};
         we = mem_we0; ty = mem_type0; a = mem_addr0;
         d  = mem_req0 ? mem_wdata0 : (if_rv0 ? if_rdata0 : d_rdata0);
      end else begin
         fl = {mem_req1, if_gnt1, d_gnt1, if_rv1, d_rv1};
         we = mem_we1; ty = mem_type1; a = mem_addr1;
         d  = mem_req1 ? mem_wdata1 : (if_rv1 ? if_rdata1 : d_rdata1);
      end
      if (fl != 5'b0) begin
         ev = mk_ev(cyc - base, fl, we, ty, a, d);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h required none", ev);
         end else begin
            exp_ev = exp_q.pop_front();
            if (ev !== exp_ev) begin
               errors++;
               $display("FAIL event: got %h required %h", ev, exp_ev);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      logic [200:0] v;
      v = {if_gnt0, if_rv0, if_rdata0, d_gnt0, d_rv0, d_rdata0, mem_req0,
           mem_we0, mem_type0, mem_addr0, mem_wdata0};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h required 0", name, v);
      end
   endtask

   task automatic end_test(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected events not seen, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Requests present while reset is held must not leak to the outputs.
      rst = 1'b1; if_req0 = 1'b1; d_req0 = 1'b1;
      if_addr0 = 32'h44; d_addr0 = 32'h88;
      repeat (3) step();
      check_zero("reset_hold");
      rst = 1'b0; if_req0 = 1'b0; d_req0 = 1'b0;
      #1;
      check_zero("post_reset_idle");

      // Fetch only.
      step();
      base = cyc;
      push(0, F_IG, 1'b0, LW, 32'h40, 32'h0);
      push(2, F_IR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0040);
      if_req0 = 1'b1; if_addr0 = 32'h40;
      step();
      if_req0 = 1'b0;
      repeat (4) step();
      end_test("fetch_only");

      // Conflict in the first cycle after reset goes to data.
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      base = cyc;
      push(0, F_DG, 1'b0, LW, 32'h200, 32'h0);
      push(2, F_DR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0200);
      push(3, F_IG, 1'b0, LW, 32'h100, 32'h0);
      push(5, F_IR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0100);
      if_req0 = 1'b1; if_addr0 = 32'h100;
      d_req0 = 1'b1; d_we0 = 1'b0; d_type0 = LW; d_addr0 = 32'h200; d_wdata0 = 32'h0;
      step();
      d_req0 = 1'b0;
      repeat (3) step();
      if_req0 = 1'b0;
      repeat (3) step();
      end_test("conflict_after_reset");

      // Both held high for 12 cycles: D,F,D,F at 0,3,6,9.
      step();
      base = cyc;
      for (int k = 0; k < 2; k++) begin
         push(6*k,     F_DG, 1'b0, LW, 32'h400, 32'h0);
         push(6*k + 2, F_DR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0400);
         push(6*k + 3, F_IG, 1'b0, LW, 32'h300, 32'h0);
         push(6*k + 5, F_IR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0300);
      end
      if_req0 = 1'b1; if_addr0 = 32'h300;
      d_req0 = 1'b1; d_addr0 = 32'h400;
      repeat (12) step();
      if_req0 = 1'b0; d_req0 = 1'b0;
      repeat (3) step();
      end_test("round_robin");

      // Store: write payload on the grant, zero read data on the response.
      step();
      base = cyc;
      push(0, F_DG, 1'b1, SW, 32'h10, 32'hDEAD_BEEF);
      push(2, F_DR, 1'b0, 3'b000, 32'h0, 32'h0);
      d_req0 = 1'b1; d_we0 = 1'b1; d_type0 = SW; d_addr0 = 32'h10; d_wdata0 = 32'hDEAD_BEEF;
      step();
      d_req0 = 1'b0; d_we0 = 1'b0; d_wdata0 = 32'h0;
      repeat (4) step();
      end_test("store");

      // Reset in cycle 1 of a load drops the response.
      step();
      base = cyc;
      push(0, F_DG, 1'b0, LBU, 32'h20, 32'h0);
      d_req0 = 1'b1; d_type0 = LBU; d_addr0 = 32'h20;
      step();
      d_req0 = 1'b0; rst = 1'b1;
      #1;
      check_zero("rst_mid_cycle1");
      step();
      rst = 1'b0;
      #1;
      check_zero("rst_mid_no_rvalid");
      repeat (4) step();
      end_test("rst_mid");

      // MEM_LAT=1 instance, fetch held high: grants 0,2,4 and rvalid 1,3,5.
      sel = 1'b1;
      step();
      base = cyc;
      for (int k = 0; k < 3; k++) begin
         push(2*k,     F_IG, 1'b0, LW, 32'h80, 32'h0);
         push(2*k + 1, F_IR, 1'b0, 3'b000, 32'h0, 32'hA5A5_0080);
      end
      if_req1 = 1'b1; if_addr1 = 32'h80;
      repeat (6) step();
      if_req1 = 1'b0;
      repeat (3) step();
      end_test("lat1_fetch");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between the CPU core's instruction-fetch port and its data-access port, so a unified memory can replace the separate instruction and data memories. The block sits between `CPU_CORE_TOP`'s imem/dmem ports and the memory. It grants one access at a time, using round-robin on conflicts, and times the memory latency. It then returns the response to the requester that owns the access.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from grant to valid `mem_rdata`; legal range 1..15

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid, 1-cycle pulse
- `if_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request; held until `d_gnt`
- `d_we`  in  1  data write enable
- `d_type`  in  3  access size/sign, funct3 encoding
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data accepted this cycle
- `d_rvalid`  out  1  data response, 1-cycle pulse (loads and stores)
- `d_rdata`  out  DATA_W  load data; 0 for stores
- `mem_req`  out  1  memory access strobe; memory samples at the edge ending this cycle
- `mem_we`  out  1  memory write
- `mem_type`  out  3  access type; fetch forces 3'b010 (word)
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  store data
- `mem_rdata`  in  DATA_W  valid exactly `MEM_LAT` cycles after the `mem_req` cycle

## Operation
- FSM states:
  - `IDLE`: arbitrates; the grant and `mem_req` are combinational in the same cycle.
  - `BUSY`: counts the latency; no grants are issued.
  - `RESP`: asserts `rvalid` to the owner; no grants are issued.
- `IDLE` behaviour:
  - With one requester active, that requester is granted.
  - With both active, the requester not granted last is granted (`last_d` register).
  - `last_d` resets to 0, so the first conflict after reset goes to data.
- On a grant:
  - `mem_*` are driven from the granted port.
  - `owner` is latched (0 = fetch, 1 = data).
  - `cnt` is loaded with `MEM_LAT-1`.
  - Next state is `BUSY`, or `RESP` directly when `MEM_LAT`=1.
- `BUSY`: `cnt` decrements each cycle; the state moves to `RESP` when `cnt`==1.
- `RESP`:
  - Asserts the owner's `rvalid`; `rdata` = `mem_rdata` combinationally, or 0 for a store.
  - Next state is `IDLE`.
- `mem_*` outputs are 0 whenever `mem_req`=0.
- Grant outputs are never asserted outside `IDLE`; at most one of `if_gnt`/`d_gnt` is asserted per cycle.
- Requests are not queued. An unserved requester keeps its `req` high and is re-arbitrated in the next `IDLE` cycle.

## Timing
- Grant in cycle N gives `rvalid` in cycle N+`MEM_LAT`, and the next possible grant in cycle N+`MEM_LAT`+1.
- Peak throughput is 1 access per `MEM_LAT`+1 cycles.
- Reset values: state `IDLE`, `cnt`=0, `owner`=0, `last_d`=0. All outputs are 0 while `rst`=1 and in the cycle after reset deasserts, unless a request is present in that cycle.
- Reset mid-transaction: the in-flight access is dropped and no `rvalid` is issued. A write already sampled by memory is not undone.
- A `req` deasserted before its grant is legal (withdrawn), with no side effects.
- Input changes during `BUSY`/`RESP` are ignored.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (`IDLE`, `BUSY`, `RESP`)
  - owner constants `OWN_IF`=0, `OWN_D`=1
  - funct3 type constants (`LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`)
  - `CNT_W`=4
- No sub-module: the round-robin pick and latency counter are small enough to stay inline.

## Test plan
- Fetch only, `MEM_LAT`=2, `if_addr`=0x40 at cycle 0:
  - cycle 0: `if_gnt`=1, `mem_req`=1, `mem_addr`=0x40, `mem_type`=3'b010.
  - cycle 2: `if_rvalid`=1, `if_rdata`=`mem_rdata`.
- Both requesting in the first cycle after reset:
  - cycle 0: `d_gnt`.
  - cycle 3: `if_gnt`.
  - never both grants in one cycle.
- Both requesting continuously for 12 cycles:
  - grants alternate D,F,D,F in cycles 0,3,6,9.
  - each `rvalid` goes only to its owner.
- Store, `d_we`=1, `d_addr`=0x10, `d_wdata`=0xDEADBEEF, `d_type`=3'b010:
  - cycle 0: `mem_we`=1 and `mem_wdata`=0xDEADBEEF.
  - cycle 2: `d_rvalid`=1 with `d_rdata`=0.
- `rst` asserted in cycle 1 of a data load: no `d_rvalid` in cycle 2, and all outputs are 0.
- `MEM_LAT`=1, fetch held high: grants in cycles 0,2,4 and `rvalid` in cycles 1,3,5.
